// File: rtl/phy_rx_deser.sv
// phy_rx_deser: serial-to-byte receiver with comma-based byte alignment.
//
// A 1-bit MSB-first stream is shifted in every clk_32f cycle. The FSM hunts for the
// comma byte BC at any bit offset (SEARCH), confirms LOCK_CNT consecutive aligned
// commas (SYNCING), then deserialises bytes (LOCKED). In LOCKED every byte boundary
// advances a 4-lane round-robin index; non-comma bytes are written to the current
// lane and strobed, comma bytes only consume the lane slot.
//
// Ports:
//   clk_32f        - bit clock, rising edge
//   reset          - asynchronous active-high reset
//   data_in        - serial data, MSB first
//   resync         - synchronous pulse, forces a return to SEARCH
//   data_out_0..3  - last byte received on each lane (held until rewritten)
//   valid_out_0..3 - one-cycle strobe per lane, at most one high at a time
//   active         - high while LOCKED
//   rx_byte_cnt    - (only with PHY_RX_BYTE_CNT_EN) count of strobed bytes, wraps
//
// Optional feature macro: PHY_RX_BYTE_CNT_EN adds rx_byte_cnt.
module phy_rx_deser #(
  parameter logic [7:0]  BC       = 8'hBC,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  input  logic        resync,
  output logic [7:0]  data_out_0,
  output logic [7:0]  data_out_1,
  output logic [7:0]  data_out_2,
  output logic [7:0]  data_out_3,
  output logic        valid_out_0,
  output logic        valid_out_1,
  output logic        valid_out_2,
  output logic        valid_out_3,
`ifdef PHY_RX_BYTE_CNT_EN
  output logic [15:0] rx_byte_cnt,
`endif
  output logic        active
);

  localparam int unsigned CntW = $clog2(LOCK_CNT + 1);
  localparam logic [CntW-1:0] LockCntV = CntW'(LOCK_CNT);
  localparam logic [CntW-1:0] OneV     = CntW'(1);

  typedef enum logic [1:0] {StSearch, StSyncing, StLocked} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] bc_cnt_q, bc_cnt_d;
  logic [1:0]      lane_idx_q, lane_idx_d;
  logic [7:0]      data_q [4];
  logic [7:0]      data_d [4];
  logic [3:0]      valid_q, valid_d;
`ifdef PHY_RX_BYTE_CNT_EN
  logic [15:0]     byte_cnt_q, byte_cnt_d;
`endif

  logic [7:0]      cand;
  logic            cand_is_bc;
  logic            boundary;
  logic [CntW-1:0] bc_cnt_inc;

  assign cand       = {shift_q[6:0], data_in};
  assign cand_is_bc = (cand == BC);
  // The 8th bit of an aligned byte is on data_in while bit_cnt sits at 7.
  assign boundary   = (bit_cnt_q == 3'd7);
  assign bc_cnt_inc = bc_cnt_q + OneV;

  // State register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q <= StSearch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; resync outranks any byte-boundary event
  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = StSearch;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (cand_is_bc) state_d = (LockCntV == OneV) ? StLocked : StSyncing;
        end
        StSyncing: begin
          if (boundary) begin
            if (!cand_is_bc)                  state_d = StSearch;
            else if (bc_cnt_inc == LockCntV)  state_d = StLocked;
          end
        end
        StLocked: state_d = StLocked;
        default:  state_d = StSearch;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    shift_d    = cand;
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    lane_idx_d = lane_idx_q;
    data_d     = data_q;
    valid_d    = 4'b0000;
`ifdef PHY_RX_BYTE_CNT_EN
    byte_cnt_d = byte_cnt_q;
`endif
    if (resync) begin
      bit_cnt_d  = 3'd0;
      bc_cnt_d   = '0;
      lane_idx_d = 2'd0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (cand_is_bc) begin
            bc_cnt_d   = OneV;
            bit_cnt_d  = 3'd0;
            lane_idx_d = 2'd0;
          end
        end
        StSyncing: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (boundary) begin
            if (cand_is_bc) begin
              bc_cnt_d = bc_cnt_inc;
              if (bc_cnt_inc == LockCntV) lane_idx_d = 2'd0;
            end else begin
              bc_cnt_d = '0;
            end
          end
        end
        StLocked: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (boundary) begin
            lane_idx_d = lane_idx_q + 2'd1;
            if (!cand_is_bc) begin
              data_d[lane_idx_q]  = cand;
              valid_d[lane_idx_q] = 1'b1;
`ifdef PHY_RX_BYTE_CNT_EN
              byte_cnt_d = byte_cnt_q + 16'd1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= '0;
      lane_idx_q <= 2'd0;
      valid_q    <= 4'b0000;
      for (int i = 0; i < 4; i++) data_q[i] <= 8'h00;
`ifdef PHY_RX_BYTE_CNT_EN
      byte_cnt_q <= 16'd0;
`endif
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      lane_idx_q <= lane_idx_d;
      valid_q    <= valid_d;
      for (int i = 0; i < 4; i++) data_q[i] <= data_d[i];
`ifdef PHY_RX_BYTE_CNT_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    active      = (state_q == StLocked);
    data_out_0  = data_q[0];
    data_out_1  = data_q[1];
    data_out_2  = data_q[2];
    data_out_3  = data_q[3];
    valid_out_0 = valid_q[0];
    valid_out_1 = valid_q[1];
    valid_out_2 = valid_q[2];
    valid_out_3 = valid_q[3];
`ifdef PHY_RX_BYTE_CNT_EN
    rx_byte_cnt = byte_cnt_q;
`endif
  end

endmodule

// File: doc/phy_rx_deser.md
PHY_RX_DESER -- requirements
Module: phy_rx_deser

Interface
REQ-001 SHALL have input clk_32f, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have input data_in, 1 bit: serial stream, MSB first, 8 bits per byte, one bit per clk_32f cycle.
REQ-004 SHALL have input resync, 1 bit: synchronous pulse that forces a return to SEARCH.
REQ-005 SHALL have outputs data_out_0..data_out_3, 8 bits each: received byte for lanes 0..3.
REQ-006 SHALL have outputs valid_out_0..valid_out_3, 1 bit each: one-cycle strobe per lane.
REQ-007 SHALL have output active, 1 bit: high while the FSM is in LOCKED.
REQ-008 SHALL have parameter BC, default 8'hBC: comma/idle byte.
REQ-009 SHALL have parameter LOCK_CNT, default 4: consecutive aligned BC bytes required to lock.

Function
REQ-010 SHALL shift data_in into an 8-bit register every cycle; the candidate byte is {shift[6:0], data_in}.
REQ-011 SHALL implement the FSM states SEARCH, SYNCING and LOCKED.
REQ-012 SEARCH: SHALL test the candidate byte every cycle; on a match with BC, set bc_cnt=1, bit_cnt=0 and go to SYNCING.
REQ-013 SYNCING: SHALL evaluate the candidate only when bit_cnt wraps 7->0; on BC, increment bc_cnt; on a non-BC byte, clear bc_cnt and go to SEARCH.
REQ-014 SHALL enter LOCKED on the boundary where bc_cnt reaches LOCK_CNT, and clear lane_idx to 0 on that transition.
REQ-015 LOCKED: at each byte boundary, a non-BC byte SHALL load data_out_<lane_idx> and pulse valid_out_<lane_idx> for exactly one cycle.
REQ-016 LOCKED: a BC byte SHALL produce no strobe and leave data_out_<lane_idx> unchanged.
REQ-017 LOCKED: lane_idx SHALL advance at every byte boundary, whether the byte is BC or not, and wrap 3->0.
REQ-018 Latency: the strobe and data SHALL be registered on the same edge that samples the 8th bit, so they are visible one cycle after the last bit is presented.
REQ-019 At most one valid_out_N SHALL be high in any cycle.
REQ-020 data_out_N SHALL hold its value until that lane is next written.
REQ-021 resync SHALL take the FSM to SEARCH on the next edge, clearing bc_cnt, bit_cnt, lane_idx and all strobes; data_out_N are kept.
REQ-022 resync SHALL take priority over any byte-boundary event in the same cycle.
REQ-023 Once locked, lock SHALL be left only by reset or resync; received data is not checked for alignment.

Reset
REQ-024 While reset is high, the block SHALL immediately set: state=SEARCH, shift=0, bit_cnt=0, bc_cnt=0, lane_idx=0.
REQ-025 While reset is high, the block SHALL immediately set: all data_out_N=8'h00, all valid_out_N=0, active=0.
REQ-026 Reset asserted mid-byte or while LOCKED SHALL discard the partial byte; after release, the block SHALL require a fresh BC search.

Configuration
REQ-027 With macro PHY_RX_BYTE_CNT_EN defined, the block SHALL add output rx_byte_cnt, 16 bits, reset to 0.
REQ-028 With PHY_RX_BYTE_CNT_EN defined, rx_byte_cnt SHALL increment on every non-BC byte strobed in LOCKED and wrap 16'hFFFF->0.
REQ-029 Without PHY_RX_BYTE_CNT_EN, the port and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-030 Send 4x BC, then bytes 11,22,33,44 -> active rises after the 4th BC; then valid_out_0..3 pulse in turn with data 8'h11/22/33/44, 8 cycles apart.
REQ-031 Send 3 leading garbage bits, then 4x BC -> the aligned lock is still achieved; no strobes occur before active=1.
REQ-032 Send BC, BC, 8'h5A, then 4x BC -> the 8'h5A byte returns the FSM to SEARCH without locking; the block locks after the following 4 BCs; no strobe occurs for 8'h5A.
REQ-033 When LOCKED, send 8'hAA, BC, 8'hCC, 8'hDD -> lane0=AA, lane1 has no strobe, lane2=CC, lane3=DD.
REQ-034 Assert reset at bit 5 of a data byte while LOCKED -> outputs clear asynchronously; assert resync while LOCKED -> active=0 next cycle.
REQ-035 With PHY_RX_BYTE_CNT_EN defined, send 6 non-BC and 2 BC bytes after lock -> rx_byte_cnt=6.
